// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C master sequencer.
//   i2c_cmd_e     - command codes on cmd_i
//   i2c_state_e   - sequencer FSM states
//   i2c_quarter_e - quarter-period phase within a START, bit or STOP
package i2c_pkg;
   typedef enum logic [1:0] {
      CMD_START = 2'd0,
      CMD_WRITE = 2'd1,
      CMD_READ  = 2'd2,
      CMD_STOP  = 2'd3
   } i2c_cmd_e;
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_BIT, ST_STOP, ST_RSP} i2c_state_e;
   typedef enum logic [1:0] {Q0, Q1, Q2, Q3} i2c_quarter_e;
   localparam int BITS_PER_BYTE = 9;
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: one-cycle tick every CLK_DIV clocks, marking quarter-SCL boundaries.
//   i_clk, i_rst  clock and synchronous active-high reset
//   i_restart     zero the count (new command accepted)
//   i_freeze      hold the count and suppress the tick (SCL being stretched)
//   o_tick        last cycle of the current quarter
module i2c_quarter_tick #(
   parameter int CLK_DIV = 250
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   input  logic i_freeze,
   output logic o_tick
);
   localparam int W = $clog2(CLK_DIV);
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
   logic [W-1:0] r_cnt;
   always_ff @(posedge i_clk) begin
      if (i_rst || i_restart) r_cnt <= '0;
      else if (!i_freeze) r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
   end
   assign o_tick = !i_freeze && r_cnt == LAST;
endmodule

// File: rtl/i2c_master_sequencer.sv
// i2c_master_sequencer: byte-level I2C master running START/WRITE/READ/STOP commands.
//   clk_i, rst_i               clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o    command handshake, accepted only in IDLE
//   cmd_i, wdata_i, ack_i      command, WRITE byte, READ acknowledge choice
//   rsp_valid_o                one-cycle completion pulse
//   rdata_o, nack_o, err_o     READ byte, WRITE NACK, illegal-command flag
//   busy_o                     bus owned between START and STOP
//   scl_bi, sda_bi             open-drain pins, only ever pulled low or released
module i2c_master_sequencer
   import i2c_pkg::*;
#(
   parameter int CLK_DIV     = 250,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [1:0] cmd_i,
   input  logic [7:0] wdata_i,
   input  logic       ack_i,
   output logic       rsp_valid_o,
   output logic [7:0] rdata_o,
   output logic       nack_o,
   output logic       err_o,
   output logic       busy_o,
   inout  wire        scl_bi,
   inout  wire        sda_bi
);
   i2c_state_e             r_state;
   i2c_quarter_e           r_q;
   logic [3:0]             r_bit;
   logic [7:0]             r_shift;
   logic                   r_is_read, r_ack, r_scl_low, r_sda_low;
   logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
   logic                   w_scl, w_sda, w_accept, w_legal, w_freeze, w_tick, w_last, w_next_low;
   assign w_scl    = r_scl_sync[SYNC_STAGES-1];
   assign w_sda    = r_sda_sync[SYNC_STAGES-1];
   assign w_accept = cmd_valid_i && cmd_ready_o;
   assign w_legal  = cmd_i == CMD_START || busy_o;
   // SCL released but still read low: either our own release has not reached the
   // synchroniser yet or the target is stretching; the quarter waits either way.
   assign w_freeze = r_state != ST_IDLE && r_state != ST_RSP && !r_scl_low && !w_scl;
   assign w_last   = r_bit == 4'(BITS_PER_BYTE - 1);
   // SDA for the bit that follows the current one; after the 9th bit SDA is left
   // as is so it only ever changes while SCL is low at the next command.
   assign w_next_low = w_last ? r_sda_low :
                       r_bit == 4'(BITS_PER_BYTE - 2) ? r_is_read && r_ack :
                       !r_is_read && !r_shift[6];
   i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .i_clk     (clk_i),
      .i_rst     (rst_i),
      .i_restart (w_accept),
      .i_freeze  (w_freeze),
      .o_tick    (w_tick)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_q         <= Q0;
         r_bit       <= '0;
         r_shift     <= '0;
         r_is_read   <= 1'b0;
         r_ack       <= 1'b0;
         r_scl_low   <= 1'b0;
         r_sda_low   <= 1'b0;
         r_scl_sync  <= '1;
         r_sda_sync  <= '1;
         cmd_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rdata_o     <= '0;
         nack_o      <= 1'b0;
         err_o       <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0], scl_bi};
         r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], sda_bi};
         rsp_valid_o <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               cmd_ready_o <= !w_accept;
               if (w_accept) begin
                  r_state     <= !w_legal ? ST_RSP : cmd_i == CMD_START ? ST_START :
                                 cmd_i == CMD_STOP ? ST_STOP : ST_BIT;
                  r_q         <= Q0;
                  r_bit       <= '0;
                  r_shift     <= wdata_i;
                  r_is_read   <= cmd_i == CMD_READ;
                  r_ack       <= ack_i;
                  r_sda_low   <= w_legal ? cmd_i == CMD_STOP || (cmd_i == CMD_WRITE && !wdata_i[7]) : r_sda_low;
                  rsp_valid_o <= !w_legal;
                  err_o       <= !w_legal;
                  nack_o      <= 1'b0;
               end
            end
            ST_START: if (w_tick) begin
               r_q <= i2c_quarter_e'(r_q + 2'd1);
               if (r_q == Q0) r_scl_low <= 1'b0;
               if (r_q == Q1) r_sda_low <= 1'b1;
               if (r_q == Q2) r_scl_low <= 1'b1;
               if (r_q == Q3) begin
                  r_state     <= ST_RSP;
                  rsp_valid_o <= 1'b1;
                  busy_o      <= 1'b1;
               end
            end
            ST_BIT: if (w_tick) begin
               r_q <= i2c_quarter_e'(r_q + 2'd1);
               if (r_q == Q1) r_scl_low <= 1'b0;
               if (r_q == Q3) begin
                  r_scl_low <= 1'b1;
                  r_sda_low <= w_next_low;
                  r_bit     <= r_bit + 4'd1;
                  if (!w_last) r_shift <= {r_shift[6:0], w_sda};
                  if (w_last) begin
                     r_state     <= ST_RSP;
                     rsp_valid_o <= 1'b1;
                     nack_o      <= !r_is_read && w_sda;
                     rdata_o     <= r_is_read ? r_shift : rdata_o;
                  end
               end
            end
            ST_STOP: if (w_tick) begin
               r_q <= i2c_quarter_e'(r_q + 2'd1);
               if (r_q == Q0) r_scl_low <= 1'b0;
               if (r_q == Q1) r_sda_low <= 1'b0;
               if (r_q == Q3) begin
                  r_state     <= ST_RSP;
                  rsp_valid_o <= 1'b1;
                  busy_o      <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               cmd_ready_o <= 1'b1;
            end
         endcase
      end
   end
   assign scl_bi = r_scl_low ? 1'b0 : 1'bz;
   assign sda_bi = r_sda_low ? 1'b0 : 1'bz;
endmodule
